rmw_write_sequencer: RTL and testbench
======================================

Name: rmw_write_sequencer

Overview:
- Upstream stage for the 8-entry x 32-bit conditional-write memory, which has a combinational read and a write-enable port.
- Accepts byte-masked write requests over a valid/ready handshake and buffers them in a small FIFO.
- Performs each request as a read-modify-write on the memory port, driving its address and enable inputs.
- Bytes with a clear mask bit keep their previous memory contents.

Parameters:
- DATA_W, 32, memory word width; must be a multiple of 8.
- ADDR_W, 32, width of the address presented to the memory. Only bits [2:0] are significant.
- DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept a request.
- req_addr  in  ADDR_W  target word address.
- req_data  in  DATA_W  new data.
- req_mask  in  DATA_W/8  byte enables; bit i covers data[8i+7:8i].
- mem_addr  out  ADDR_W  address driven to the memory, used for both read and write.
- mem_rdata  in  DATA_W  combinational read data for mem_addr.
- mem_wen  out  1  memory write enable for this cycle.
- mem_wdata  out  DATA_W  merged write data.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- done  out  1  one-cycle pulse when a request retires.
- done_cnt  out  16  count of retired requests; wraps.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job):
  - FIFO emptied; FSM to IDLE.
  - mem_wen=0, mem_addr=0, mem_wdata=0, done=0, done_cnt=0, busy=0.
  - req_ready=1 once reset is released.
- Reset asserted mid-operation:
  - Any in-flight request is abandoned and no partial write is issued.
  - mem_wen drops to 0 immediately (asynchronously).
- Enqueue:
  - A request is accepted on a clk edge when req_valid && req_ready.
  - req_ready = !full. There is no bypass: a full FIFO does not accept even when it pops in the same cycle.
  - Requests are stored with address bits [2:0] only; mem_addr zero-extends them.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, pop the head into working registers (addr, data, mask).
    - mask all ones -> WRITE.
    - mask zero -> RETIRE.
    - otherwise -> READ.
  - READ (1 cycle):
    - mem_addr = working addr; mem_wen = 0.
    - At the clock edge, merged = (mem_rdata & ~bytemask) | (data & bytemask), where bytemask expands each mask bit to 8 bits.
    - -> WRITE.
  - WRITE (1 cycle):
    - mem_addr = working addr; mem_wen = 1.
    - mem_wdata = merged, or data when the mask is all ones.
    - -> RETIRE.
  - RETIRE (1 cycle):
    - done = 1; done_cnt increments, 0xFFFF wraps to 0.
    - -> IDLE.
- Latency:
  - Partial mask: 4 cycles from pop to the done pulse (IDLE, READ, WRITE, RETIRE).
  - Full mask: 3 cycles.
  - Zero mask: 2 cycles, with no memory access.
- Output timing:
  - mem_wen is registered and asserted only in WRITE. It is never asserted in the same cycle as READ for any address.
  - mem_addr is registered. It holds its last value in IDLE and RETIRE.
- Ordering:
  - Requests retire strictly in FIFO order.
  - Back-to-back requests to the same address are safe: the READ of request N+1 occurs after the WRITE of N has committed.
- Simultaneous events:
  - A push and a pop in the same cycle are allowed when the FIFO is neither empty nor full; occupancy is unchanged.
  - Pushing into an empty FIFO while in IDLE: the request is popped on the following cycle (no bypass).
- Pointers: log2(DEPTH)+1 bits with the wrap bit; full/empty decode from the pointers.
- busy is a combinational OR of (state != IDLE) and !empty.

Test Plan:
1. Full mask:
   - Stimulus: reset; memory[3]=0x11223344; push addr=3, data=0xAABBCCDD, mask=0xF.
   - Required: no READ cycle; exactly one mem_wen pulse with mem_addr=3, mem_wdata=0xAABBCCDD; done 3 cycles after pop; done_cnt=1.
2. Partial mask:
   - Stimulus: memory[5]=0x11223344; push addr=5, data=0xAABBCCDD, mask=0x3.
   - Required: READ cycle with mem_wen=0; WRITE cycle with mem_wdata=0x1122CCDD.
3. Zero mask:
   - Stimulus: push mask=0x0.
   - Required: mem_wen stays 0 throughout; done pulses; done_cnt increments.
4. Backpressure and ordering:
   - Stimulus: hold req_valid for 6 requests while the sequencer is busy (DEPTH=4).
   - Required: req_ready=0 once 4 are queued; all 6 retire in order; no request lost or duplicated.
5. Same-address chain:
   - Stimulus: memory[2]=0; push addr=2 mask=0x1 data=0xFF, then addr=2 mask=0x2 data=0xFF00.
   - Required: final memory[2]=0x0000FFFF.
6. Reset during READ:
   - Stimulus: assert reset_n=0 while in READ with 2 requests queued.
   - Required: mem_wen=0 immediately; after release busy=0, done_cnt=0, memory unchanged.
7. Counter wrap:
   - Stimulus: force done_cnt=0xFFFF, then retire one request.
   - Required: done_cnt=0x0000.

Source files
------------

// File: rtl/rmw_write_sequencer.sv
// Byte-masked write sequencer: buffers requests in a small FIFO and turns each
// one into a read-modify-write on an 8-entry combinational-read memory port.
module rmw_write_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_data,
    input  logic [DATA_W/8-1:0] req_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                busy,
    output logic                done,
    output logic [15:0]         done_cnt
);

    localparam int MASK_W = DATA_W / 8;
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PTR_W  = IDX_W + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_READ   = 2'd1;
    localparam logic [1:0] ST_WRITE  = 2'd2;
    localparam logic [1:0] ST_RETIRE = 2'd3;

    localparam logic [PTR_W-1:0]  PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [MASK_W-1:0] MASK_ONES = {MASK_W{1'b1}};
    localparam logic [MASK_W-1:0] MASK_NONE = {MASK_W{1'b0}};

    // Expand one enable bit per byte into a full-width bit mask.
    function automatic logic [DATA_W-1:0] expand_mask(input logic [MASK_W-1:0] m);
        logic [DATA_W-1:0] r;
        r = {DATA_W{1'b0}};
        for (int i = 0; i < MASK_W; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    logic [2:0]        fifo_addr_r [DEPTH];
    logic [DATA_W-1:0] fifo_data_r [DEPTH];
    logic [MASK_W-1:0] fifo_mask_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [DATA_W-1:0] work_data_r;
    logic [MASK_W-1:0] work_mask_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_wen_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              done_r;
    logic [15:0]       done_cnt_r;

    logic              empty_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;
    logic [2:0]        head_addr_s;
    logic [DATA_W-1:0] head_data_s;
    logic [MASK_W-1:0] head_mask_s;
    logic [DATA_W-1:0] merged_s;
    logic              unused_addr_s;

    // Only the low three address bits reach the FIFO; the rest are ignored.
    assign unused_addr_s = ^req_addr[ADDR_W-1:3];

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                       (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign req_ready = !full_s;
    assign push_s    = req_valid && !full_s;
    assign pop_s     = (state_r == ST_IDLE) && !empty_s;

    assign head_addr_s = fifo_addr_r[rd_ptr_r[IDX_W-1:0]];
    assign head_data_s = fifo_data_r[rd_ptr_r[IDX_W-1:0]];
    assign head_mask_s = fifo_mask_r[rd_ptr_r[IDX_W-1:0]];

    // Unmasked bytes come from the memory, masked bytes from the request.
    assign merged_s = (mem_rdata & ~expand_mask(work_mask_r)) |
                      (work_data_r & expand_mask(work_mask_r));

    assign busy      = (state_r != ST_IDLE) || !empty_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wen   = mem_wen_r;
    assign mem_wdata = mem_wdata_r;
    assign done      = done_r;
    assign done_cnt  = done_cnt_r;

    // Request FIFO storage and pointers; the wrap bit separates full from empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                fifo_addr_r[i] <= 3'd0;
                fifo_data_r[i] <= {DATA_W{1'b0}};
                fifo_mask_r[i] <= {MASK_W{1'b0}};
            end
        end else begin
            if (push_s) begin
                fifo_addr_r[wr_ptr_r[IDX_W-1:0]] <= req_addr[2:0];
                fifo_data_r[wr_ptr_r[IDX_W-1:0]] <= req_data;
                fifo_mask_r[wr_ptr_r[IDX_W-1:0]] <= req_mask;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Next-state decode: the mask of the popped request picks the path.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s) begin
                    if (head_mask_s == MASK_ONES) begin
                        state_nxt_s = ST_WRITE;
                    end else if (head_mask_s == MASK_NONE) begin
                        state_nxt_s = ST_RETIRE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ:   state_nxt_s = ST_WRITE;
            ST_WRITE:  state_nxt_s = ST_RETIRE;
            ST_RETIRE: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, working registers and all registered memory/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            work_data_r <= {DATA_W{1'b0}};
            work_mask_r <= {MASK_W{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wen_r   <= 1'b0;
            mem_wdata_r <= {DATA_W{1'b0}};
            done_r      <= 1'b0;
            done_cnt_r  <= 16'd0;
        end else begin
            state_r   <= state_nxt_s;
            mem_wen_r <= (state_nxt_s == ST_WRITE);
            done_r    <= (state_nxt_s == ST_RETIRE);
            if (pop_s) begin
                work_data_r <= head_data_s;
                work_mask_r <= head_mask_s;
            end
            // Zero-mask requests never touch the memory, so the address holds.
            if (pop_s && (head_mask_s != MASK_NONE)) begin
                mem_addr_r <= {{(ADDR_W-3){1'b0}}, head_addr_s};
            end
            if (pop_s && (head_mask_s == MASK_ONES)) begin
                mem_wdata_r <= head_data_s;
            end else if (state_r == ST_READ) begin
                mem_wdata_r <= merged_s;
            end
            if (state_nxt_s == ST_RETIRE) begin
                done_cnt_r <= done_cnt_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rmw_write_sequencer.sv
// Directed bench for rmw_write_sequencer with a behavioural 8x32 memory.
module tb_rmw_write_sequencer;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_mask;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [15:0] done_cnt;

    int n_cmp;
    int n_err;

    bit [31:0] mem_model [8];
    bit [31:0] mem_snap  [8];
    int        wen_count;
    bit [2:0]  wlog_addr [64];
    bit [31:0] wlog_data [64];
    logic      pl_en;
    logic [2:0]  pl_addr;
    logic [31:0] pl_data;

    rmw_write_sequencer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_mask  (req_mask),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .done_cnt  (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_model[mem_addr[2:0]];

    // Memory model: commits DUT writes, otherwise applies bench preloads.
    always @(posedge clk) begin
        if (mem_wen) begin
            mem_model[mem_addr[2:0]] <= mem_wdata;
            wlog_addr[wen_count[5:0]] <= mem_addr[2:0];
            wlog_data[wen_count[5:0]] <= mem_wdata;
            wen_count <= wen_count + 1;
        end else if (pl_en) begin
            mem_model[pl_addr] <= pl_data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_mem(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Drive one request; returns just after the accepting edge.
    task automatic push_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; req_data = d; req_mask = m;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("push_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base;
        int n;
        n_cmp = 0; n_err = 0;
        wen_count = 0;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 32'd0;
        req_valid = 1'b0; req_addr = 32'd0; req_data = 32'd0; req_mask = 4'd0;
        reset_n = 1'b0;

        // Reset state
        #3;
        check_eq("rst_wen",   {31'd0, mem_wen}, 32'd0);
        check_eq("rst_addr",  mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_done",  {31'd0, done}, 32'd0);
        check_eq("rst_cnt",   {16'd0, done_cnt}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);

        // 1: full mask, no READ cycle
        set_mem(3'd3, 32'h11223344);
        push_one(32'd3, 32'hAABBCCDD, 4'hF);
        @(negedge clk);
        check_eq("t1_idle_wen", {31'd0, mem_wen}, 32'd0);
        check_eq("t1_idle_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_eq("t1_wr_wen", {31'd0, mem_wen}, 32'd1);
        check_eq("t1_wr_addr", mem_addr, 32'd3);
        check_eq("t1_wr_data", mem_wdata, 32'hAABBCCDD);
        @(negedge clk);
        check_eq("t1_done", {31'd0, done}, 32'd1);
        check_eq("t1_cnt", {16'd0, done_cnt}, 32'd1);
        check_eq("t1_ret_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        check_eq("t1_done_off", {31'd0, done}, 32'd0);
        check_eq("t1_busy_off", {31'd0, busy}, 32'd0);
        check_eq("t1_mem", mem_model[3], 32'hAABBCCDD);
        check_eq("t1_wen_pulses", wen_count, 32'd1);

        // 2: partial mask merges with the read data
        set_mem(3'd5, 32'h11223344);
        push_one(32'd5, 32'hAABBCCDD, 4'h3);
        @(negedge clk);
        check_eq("t2_idle_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        check_eq("t2_rd_wen", {31'd0, mem_wen}, 32'd0);
        check_eq("t2_rd_addr", mem_addr, 32'd5);
        @(negedge clk);
        check_eq("t2_wr_wen", {31'd0, mem_wen}, 32'd1);
        check_eq("t2_wr_data", mem_wdata, 32'h1122CCDD);
        @(negedge clk);
        check_eq("t2_done", {31'd0, done}, 32'd1);
        check_eq("t2_cnt", {16'd0, done_cnt}, 32'd2);
        check_eq("t2_mem", mem_model[5], 32'h1122CCDD);

        // 3: zero mask never touches memory
        base = wen_count;
        push_one(32'd1, 32'h12345678, 4'h0);
        @(negedge clk);
        check_eq("t3_idle_wen", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        check_eq("t3_done", {31'd0, done}, 32'd1);
        check_eq("t3_cnt", {16'd0, done_cnt}, 32'd3);
        check_eq("t3_wen", {31'd0, mem_wen}, 32'd0);
        wait_idle();
        check_eq("t3_no_write", wen_count, base);

        // 4: backpressure and ordering with six held requests
        base = wen_count;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_addr = i; req_data = 32'hC0DE0000 + i; req_mask = 4'hF;
            n = 0;
            while (!req_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check_eq("t4_ready_to", {31'd0, req_ready}, 32'd1);
            @(posedge clk);
        end
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_eq("t4_full", {31'd0, req_ready}, 32'd0);
        wait_idle();
        check_eq("t4_cnt", {16'd0, done_cnt}, 32'd9);
        check_eq("t4_writes", wen_count - base, 32'd6);
        for (int i = 0; i < 6; i++) begin
            check_eq("t4_ord_addr", {29'd0, wlog_addr[base + i]}, i);
            check_eq("t4_ord_data", wlog_data[base + i], 32'hC0DE0000 + i);
        end

        // 5: same-address chain
        set_mem(3'd2, 32'h0);
        push_one(32'd2, 32'h000000FF, 4'h1);
        push_one(32'd2, 32'h0000FF00, 4'h2);
        wait_idle();
        check_eq("t5_mem", mem_model[2], 32'h0000FFFF);
        check_eq("t5_cnt", {16'd0, done_cnt}, 32'd11);

        // 6: reset while the second request is in READ with two queued
        push_one(32'd4, 32'h000000AA, 4'h1);
        push_one(32'd6, 32'hDEADBEEF, 4'h5);
        push_one(32'd7, 32'h5555AAAA, 4'h3);
        push_one(32'd7, 32'h99999999, 4'hF);
        n = 0;
        @(negedge clk);
        while (mem_addr != 32'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_in_read", mem_addr, 32'd6);
        for (int i = 0; i < 8; i++) mem_snap[i] = mem_model[i];
        reset_n = 1'b0;
        #1;
        check_eq("t6_wen_async", {31'd0, mem_wen}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        check_eq("t6_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_cnt", {16'd0, done_cnt}, 32'd0);
        check_eq("t6_ready", {31'd0, req_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_eq("t6_mem", mem_model[i], mem_snap[i]);
        end

        // 7: done counter wraps
        @(negedge clk);
        force dut.done_cnt_r = 16'hFFFF;
        #1 release dut.done_cnt_r;
        @(negedge clk);
        check_eq("t7_preset", {16'd0, done_cnt}, 32'h0000FFFF);
        push_one(32'd0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check_eq("t7_done", {31'd0, done}, 32'd1);
        check_eq("t7_wrap", {16'd0, done_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
